// File: rtl/scene_compositor_p.sv
// scene_compositor_p
//   Composites a shaded sphere over a scrolling checkerboard floor over a sky
//   gradient, then quantises each channel from IN_BITS to OUT_BITS with
//   ordered, temporal or no dithering. Fixed 2-cycle latency, 1 pixel/clock.
//
// Ports:
//   clk            pixel clock
//   rst            asynchronous, active-high reset
//   h_count        raster column (11 bits)
//   v_count        raster line (10 bits)
//   frame_start    one-cycle pulse per frame (vertical blanking)
//   sphere_visible sphere covers this pixel
//   sphere_luma    sphere brightness (IN_BITS)
//   mode           0 ordered dither, 1 temporal dither, 2/3 truncate
//   tint_sel       0 warm sphere tint, 1 cool sphere tint
//   r_out/g_out/b_out  quantised colour (OUT_BITS each)
//   de_out         pixel in active area, aligned with colour outputs
module scene_compositor_p #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int IN_BITS     = 6,
    parameter int OUT_BITS    = 2,
    parameter int HORIZON     = 240,
    parameter int TILE_H_LOG2 = 5,
    parameter int TILE_V_LOG2 = 4,
    parameter int SCROLL_STEP = 1,
    parameter int TILE_BRIGHT = 40,
    parameter int TILE_DIM    = 20,
    parameter int SKY_TOP     = 60,
    parameter int SKY_MIN     = 16,
    parameter int SKY_SHIFT   = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [10:0]         h_count,
    input  logic [9:0]          v_count,
    input  logic                frame_start,
    input  logic                sphere_visible,
    input  logic [IN_BITS-1:0]  sphere_luma,
    input  logic [1:0]          mode,
    input  logic                tint_sel,
    output logic [OUT_BITS-1:0] r_out,
    output logic [OUT_BITS-1:0] g_out,
    output logic [OUT_BITS-1:0] b_out,
    output logic                de_out
);

    localparam int D     = IN_BITS - OUT_BITS;
    localparam int SW    = TILE_H_LOG2 + 1;
    localparam int SUM_W = D + OUT_BITS + 1;
    // Bayer entries are 4-bit; scale them to span the D discarded bits.
    localparam int TSHL  = (D >= 4) ? D - 4 : 0;
    localparam int TSHR  = (D >= 4) ? 0 : 4 - D;

    // Only the tile-width bit of (h + scroll) matters, so the sum is taken
    // modulo 2^(TILE_H_LOG2+1), which is also the scroll register width.
    function automatic logic tile_parity(input logic [SW-1:0] hx,
                                         input logic [SW-1:0] sc,
                                         input logic          v_bit);
        logic [SW-1:0] s;
        s = hx + sc;
        return s[SW-1] ^ v_bit;
    endfunction

    // Sky level clamps at SKY_MIN; the subtraction is done signed and wide
    // enough that deep lines cannot wrap to a bright value.
    function automatic logic [IN_BITS-1:0] sky_level(input logic [9:0] v);
        logic signed [11:0] top_s;
        logic signed [11:0] dec_s;
        logic signed [11:0] diff;
        top_s = 12'(SKY_TOP);
        dec_s = $signed({2'b00, v >> SKY_SHIFT});
        diff  = top_s - dec_s;
        if (diff < $signed(12'(SKY_MIN)))
            return IN_BITS'(SKY_MIN);
        return diff[IN_BITS-1:0];
    endfunction

    function automatic logic [3:0] bayer(input logic [1:0] x, input logic [1:0] y);
        logic [3:0] b;
        case ({y, x})
            4'h0: b = 4'd0;   4'h1: b = 4'd8;   4'h2: b = 4'd2;   4'h3: b = 4'd10;
            4'h4: b = 4'd12;  4'h5: b = 4'd4;   4'h6: b = 4'd14;  4'h7: b = 4'd6;
            4'h8: b = 4'd3;   4'h9: b = 4'd11;  4'hA: b = 4'd1;   4'hB: b = 4'd9;
            4'hC: b = 4'd15;  4'hD: b = 4'd7;   4'hE: b = 4'd13;  default: b = 4'd5;
        endcase
        return b;
    endfunction

    // Add threshold, drop D bits, saturate. SUM_W bits hold the worst case.
    function automatic logic [OUT_BITS-1:0] quantise(input logic [IN_BITS-1:0] c,
                                                     input logic [3:0]         thr,
                                                     input logic               trunc);
        logic [SUM_W-1:0] t;
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] q;
        t   = trunc ? '0 : ((SUM_W'(thr) << TSHL) >> TSHR);
        sum = SUM_W'(c) + t;
        q   = sum >> D;
        if (|q[SUM_W-1:OUT_BITS])
            return '1;
        return q[OUT_BITS-1:0];
    endfunction

    // Per-frame state; a pixel sampled alongside frame_start sees old values.
    logic [1:0]    frame_cnt;
    logic [SW-1:0] scroll;
    logic [1:0]    mode_q;
    logic          tint_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            scroll    <= '0;
            mode_q    <= '0;
            tint_q    <= 1'b0;
        end else if (frame_start) begin
            frame_cnt <= frame_cnt + 2'd1;
            scroll    <= scroll + SW'(SCROLL_STEP);
            mode_q    <= mode;
            tint_q    <= tint_sel;
        end
    end

    // ---- Stage 1: classify and shade ----
    logic               active_c;
    logic               ground_c;
    logic [IN_BITS-1:0] floor_lvl;
    logic [IN_BITS-1:0] r_c, g_c, b_c;

    always_comb begin
        active_c  = (h_count < 11'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));
        ground_c  = v_count > 10'(HORIZON);
        floor_lvl = tile_parity(h_count[SW-1:0], scroll, v_count[TILE_V_LOG2])
                    ? IN_BITS'(TILE_BRIGHT) : IN_BITS'(TILE_DIM);
        r_c = '0;
        g_c = '0;
        b_c = sky_level(v_count);
        if (sphere_visible) begin
            g_c = sphere_luma >> 1;
            if (tint_q) begin
                r_c = sphere_luma >> 2;
                b_c = sphere_luma;
            end else begin
                r_c = sphere_luma;
                b_c = sphere_luma >> 2;
            end
        end else if (ground_c) begin
            r_c = floor_lvl;
            g_c = floor_lvl;
            b_c = floor_lvl;
        end
    end

    logic [IN_BITS-1:0] r_p1, g_p1, b_p1;
    logic               vld_p1;
    logic [1:0]         hx_p1, vy_p1, fc_p1, md_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1   <= '0;
            g_p1   <= '0;
            b_p1   <= '0;
            vld_p1 <= 1'b0;
            hx_p1  <= '0;
            vy_p1  <= '0;
            fc_p1  <= '0;
            md_p1  <= '0;
        end else begin
            r_p1   <= r_c;
            g_p1   <= g_c;
            b_p1   <= b_c;
            vld_p1 <= active_c;
            hx_p1  <= h_count[1:0];
            vy_p1  <= v_count[1:0];
            fc_p1  <= frame_cnt;
            md_p1  <= mode_q;
        end
    end

    // ---- Stage 2: dither and quantise ----
    logic [1:0] dx_c;
    logic [3:0] thr_c;
    logic       trunc_c;

    always_comb begin
        dx_c    = (md_p1 == 2'd1) ? (hx_p1 ^ fc_p1) : hx_p1;
        thr_c   = bayer(dx_c, vy_p1);
        trunc_c = md_p1[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            de_out <= 1'b0;
        end else begin
            r_out  <= vld_p1 ? quantise(r_p1, thr_c, trunc_c) : '0;
            g_out  <= vld_p1 ? quantise(g_p1, thr_c, trunc_c) : '0;
            b_out  <= vld_p1 ? quantise(b_p1, thr_c, trunc_c) : '0;
            de_out <= vld_p1;
        end
    end

endmodule

// File: tb/tb_scene_compositor_p.sv
module tb_scene_compositor_p;

    logic        clk;
    logic        rst;
    logic [10:0] h_count;
    logic [9:0]  v_count;
    logic        frame_start;
    logic        sphere_visible;
    logic [5:0]  sphere_luma;
    logic [1:0]  mode;
    logic        tint_sel;
    logic [1:0]  r_out, g_out, b_out;
    logic        de_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference frame state and two-deep expectation pipe.
    int m_fc, m_sc, m_md, m_tn;
    logic [6:0] e0, e1;

    int bayer_tab[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    scene_compositor_p dut (
        .clk            (clk),
        .rst            (rst),
        .h_count        (h_count),
        .v_count        (v_count),
        .frame_start    (frame_start),
        .sphere_visible (sphere_visible),
        .sphere_luma    (sphere_luma),
        .mode           (mode),
        .tint_sel       (tint_sel),
        .r_out          (r_out),
        .g_out          (g_out),
        .b_out          (b_out),
        .de_out         (de_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int qz(int c, int t);
        int o;
        o = (c + t) / 16;
        return (o > 3) ? 3 : o;
    endfunction

    // Expected {de, r, g, b} for one pixel given the frame state it sees.
    function automatic logic [6:0] model_pix(int h, int v, bit sv, int lum,
                                             int md, int tn, int fc, int sc);
        int r, g, b, lvl, x, y, t;
        logic [6:0] res;
        if (!(h < 640 && v < 480)) return 7'd0;
        if (sv) begin
            g = lum / 2;
            if (tn == 0) begin r = lum; b = lum / 4; end
            else begin r = lum / 4; b = lum; end
        end else if (v > 240) begin
            lvl = ((((h + sc) / 32) % 2) ^ ((v / 16) % 2)) ? 40 : 20;
            r = lvl; g = lvl; b = lvl;
        end else begin
            r = 0; g = 0;
            b = 60 - v / 8;
            if (b < 16) b = 16;
        end
        x = h % 4;
        if (md == 1) x = x ^ fc;
        y = v % 4;
        t = (md >= 2) ? 0 : bayer_tab[y * 4 + x];
        res = {1'b1, 2'(qz(r, t)), 2'(qz(g, t)), 2'(qz(b, t))};
        return res;
    endfunction

    task automatic step(int h, int v, bit fs, bit sv, int lum, int md, int tn);
        @(negedge clk);
        chk("pix", 32'({de_out, r_out, g_out, b_out}), 32'(e1));
        e1 = e0;
        h_count        = h[10:0];
        v_count        = v[9:0];
        frame_start    = fs;
        sphere_visible = sv;
        sphere_luma    = lum[5:0];
        mode           = md[1:0];
        tint_sel       = tn[0];
        e0 = model_pix(h, v, sv, lum, m_md, m_tn, m_fc, m_sc);
        if (fs) begin
            m_fc = (m_fc + 1) % 4;
            m_sc = (m_sc + 1) % 64;
            m_md = md;
            m_tn = tn;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        h_count = 11'd640; v_count = '0; frame_start = 1'b0;
        sphere_visible = 1'b0; sphere_luma = '0; mode = '0; tint_sel = 1'b0;
        m_fc = 0; m_sc = 0; m_md = 0; m_tn = 0;
        e0 = '0; e1 = '0;
    endtask

    initial begin
        rst = 1'b1;
        h_count = '0; v_count = '0; frame_start = 1'b0;
        sphere_visible = 1'b0; sphere_luma = '0; mode = '0; tint_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("reset_state", 32'({de_out, r_out, g_out, b_out}), 32'd0);
        release_reset();

        // Truncate mode; sky top, then floor at bottom line.
        step(640, 0, 1, 0, 0, 2, 0);
        repeat (3) step(0, 0, 0, 0, 0, 2, 0);
        repeat (3) step(0, 479, 0, 0, 0, 2, 0);
        step(100, 300, 0, 0, 0, 2, 0);

        // Sphere tint: warm, then cool after frame_start, then ignored change.
        repeat (3) step(0, 100, 0, 1, 63, 2, 0);
        step(640, 490, 1, 0, 0, 2, 1);
        repeat (3) step(0, 100, 0, 1, 63, 2, 1);
        repeat (3) step(0, 100, 0, 1, 63, 2, 0);

        // Floor scroll across a full wrap, sampled every frame.
        for (int i = 0; i < 66; i++) step(0, 241, 1, 0, 0, 2, 0);
        repeat (2) step(0, 241, 0, 0, 0, 2, 0);

        // Ordered dither on a bright sphere.
        step(640, 490, 1, 0, 0, 0, 0);
        repeat (3) step(0, 1, 0, 1, 63, 0, 0);
        repeat (3) step(1, 2, 0, 1, 40, 0, 0);

        // Temporal dither over several frames.
        step(640, 490, 1, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) step(0, 0, (i % 2) == 1, 1, 16, 1, 0);

        // Inactive pixels.
        step(640, 0, 0, 1, 63, 1, 0);
        step(639, 479, 0, 1, 63, 1, 0);
        step(0, 480, 0, 1, 63, 1, 0);
        repeat (3) step(0, 0, 0, 0, 0, 1, 0);

        // Asynchronous reset mid-frame with nonzero outputs.
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("rst_async", 32'({de_out, r_out, g_out, b_out}), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'({de_out, r_out, g_out, b_out}), 32'd0);
        release_reset();
        repeat (4) step(0, 0, 0, 0, 0, 0, 0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 700), $urandom_range(0, 520),
                 ($urandom % 16) == 0, $urandom % 2,
                 $urandom_range(0, 63), $urandom_range(0, 3), $urandom % 2);
        end
        repeat (2) step(640, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
